board_ctl: RTL and testbench

BOARD_CTL -- requirements
Module: board_ctl

---
 rtl/board_ctl.sv | 237 +++++++++++++++++++++++
 tb/tb_board_ctl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctl.sv
// Purpose: controls one battleship board in an external 2-bit-per-cell RAM (clear, place/remove ship, resolve shot).
// Latency: shot/place results 3 clk after the request; out-of-range error 1 clk after; clear takes X_SIZE*Y_SIZE clk.
// Backpressure: none; requests are sampled only while idle (busy = 0) and are silently dropped otherwise.
module board_ctl #(
    parameter int X_SIZE         = 12,
    parameter int Y_SIZE         = 12,
    parameter int MAX_SHIP_CELLS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_req,
    input  logic       place_req,
    input  logic [7:0] place_xy,
    input  logic       shot_req,
    input  logic [7:0] shot_xy,
    output logic [7:0] mem_addr,
    output logic [1:0] mem_wdata,
    output logic       mem_w_nr,
    input  logic [1:0] mem_rdata,
    output logic       busy,
    output logic       clear_done,
    output logic       place_ok,
    output logic       place_err,
    output logic       shot_done,
    output logic       shot_hit,
    output logic       shot_err,
    output logic [4:0] ships_left
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RD,
        CHK,
        WR
    } state_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    // Limits widened to 5 bits so a 16-wide board compares correctly against 4-bit coordinates.
    localparam logic [4:0] X_LIM     = 5'(X_SIZE);
    localparam logic [4:0] Y_LIM     = 5'(Y_SIZE);
    localparam logic [3:0] X_LAST    = 4'(X_SIZE - 1);
    localparam logic [3:0] Y_LAST    = 4'(Y_SIZE - 1);
    localparam logic [4:0] MAX_SHIPS = 5'(MAX_SHIP_CELLS);

    state_t     state;
    state_t     state_nxt;
    // Set by reset so the first edge after release starts a board clear.
    logic       init_pend;
    logic       init_pend_nxt;
    // Remembers whether the read in flight belongs to a shot (1) or a place (0).
    logic       op_shot;
    logic       op_shot_nxt;

    logic [7:0] mem_addr_nxt;
    logic [1:0] mem_wdata_nxt;
    logic       mem_w_nr_nxt;
    logic       busy_nxt;
    logic       clear_done_nxt;
    logic       place_ok_nxt;
    logic       place_err_nxt;
    logic       shot_done_nxt;
    logic       shot_hit_nxt;
    logic       shot_err_nxt;
    logic [4:0] ships_left_nxt;

    function automatic logic in_range(input logic [7:0] xy);
        return ({1'b0, xy[7:4]} < X_LIM) && ({1'b0, xy[3:0]} < Y_LIM);
    endfunction

    // State and every output are registered; reset aborts any operation, so a pending write never lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            init_pend  <= 1'b1;
            op_shot    <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= CELL_EMPTY;
            mem_w_nr   <= 1'b0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            place_ok   <= 1'b0;
            place_err  <= 1'b0;
            shot_done  <= 1'b0;
            shot_hit   <= 1'b0;
            shot_err   <= 1'b0;
            ships_left <= 5'd0;
        end else begin
            state      <= state_nxt;
            init_pend  <= init_pend_nxt;
            op_shot    <= op_shot_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_w_nr   <= mem_w_nr_nxt;
            busy       <= busy_nxt;
            clear_done <= clear_done_nxt;
            place_ok   <= place_ok_nxt;
            place_err  <= place_err_nxt;
            shot_done  <= shot_done_nxt;
            shot_hit   <= shot_hit_nxt;
            shot_err   <= shot_err_nxt;
            ships_left <= ships_left_nxt;
        end
    end

    // Next state plus the output values the registers will present in that next state.
    always_comb begin
        state_nxt      = state;
        init_pend_nxt  = init_pend;
        op_shot_nxt    = op_shot;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = CELL_EMPTY;
        mem_w_nr_nxt   = 1'b0;
        clear_done_nxt = 1'b0;
        place_ok_nxt   = 1'b0;
        place_err_nxt  = 1'b0;
        shot_done_nxt  = 1'b0;
        shot_hit_nxt   = 1'b0;
        shot_err_nxt   = 1'b0;
        ships_left_nxt = ships_left;

        case (state)
            IDLE: begin
                // Priority: post-reset/explicit clear, then shot, then place.
                if (init_pend || clear_req) begin
                    state_nxt     = CLEAR;
                    init_pend_nxt = 1'b0;
                    mem_addr_nxt  = 8'h00;
                    mem_w_nr_nxt  = 1'b1;
                end else if (shot_req) begin
                    if (in_range(shot_xy)) begin
                        state_nxt    = RD;
                        op_shot_nxt  = 1'b1;
                        mem_addr_nxt = shot_xy;
                    end else begin
                        shot_err_nxt = 1'b1;
                    end
                end else if (place_req) begin
                    if (in_range(place_xy)) begin
                        state_nxt    = RD;
                        op_shot_nxt  = 1'b0;
                        mem_addr_nxt = place_xy;
                    end else begin
                        place_err_nxt = 1'b1;
                    end
                end
            end

            CLEAR: begin
                // mem_addr doubles as the sweep cursor: y is the inner loop, x the outer.
                if (mem_addr[7:4] == X_LAST && mem_addr[3:0] == Y_LAST) begin
                    state_nxt      = IDLE;
                    clear_done_nxt = 1'b1;
                    ships_left_nxt = 5'd0;
                end else begin
                    mem_w_nr_nxt = 1'b1;
                    if (mem_addr[3:0] == Y_LAST) begin
                        mem_addr_nxt = {mem_addr[7:4] + 4'd1, 4'h0};
                    end else begin
                        mem_addr_nxt = {mem_addr[7:4], mem_addr[3:0] + 4'd1};
                    end
                end
            end

            RD: begin
                state_nxt = CHK;
            end

            CHK: begin
                // mem_rdata now holds the cell; decide the write and result pulses shown in WR.
                state_nxt = WR;
                if (op_shot) begin
                    shot_done_nxt = 1'b1;
                    case (mem_rdata)
                        CELL_SHIP: begin
                            mem_w_nr_nxt  = 1'b1;
                            mem_wdata_nxt = CELL_HIT;
                            shot_hit_nxt  = 1'b1;
                            if (ships_left != 5'd0) begin
                                ships_left_nxt = ships_left - 5'd1;
                            end
                        end
                        CELL_EMPTY: begin
                            mem_w_nr_nxt  = 1'b1;
                            mem_wdata_nxt = CELL_MISS;
                        end
                        CELL_HIT: begin
                            shot_hit_nxt = 1'b1;
                        end
                        default: begin
                            shot_hit_nxt = 1'b0;
                        end
                    endcase
                end else begin
                    case (mem_rdata)
                        CELL_EMPTY: begin
                            if (ships_left < MAX_SHIPS) begin
                                mem_w_nr_nxt   = 1'b1;
                                mem_wdata_nxt  = CELL_SHIP;
                                ships_left_nxt = ships_left + 5'd1;
                                place_ok_nxt   = 1'b1;
                            end else begin
                                place_err_nxt = 1'b1;
                            end
                        end
                        CELL_SHIP: begin
                            mem_w_nr_nxt  = 1'b1;
                            mem_wdata_nxt = CELL_EMPTY;
                            place_ok_nxt  = 1'b1;
                            if (ships_left != 5'd0) begin
                                ships_left_nxt = ships_left - 5'd1;
                            end
                        end
                        default: begin
                            place_err_nxt = 1'b1;
                        end
                    endcase
                end
            end

            WR: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_board_ctl.sv
// Purpose: directed table-driven bench for board_ctl with a behavioural 2-bit board RAM.
// Latency: checks result timing at N+1 (errors / read address) and N+3 (write and pulses).
// Backpressure: drives requests only while idle, except deliberate drops during clear.
module tb_board_ctl;

    localparam int K_POK  = 0;
    localparam int K_PERR = 1;
    localparam int K_OOR  = 2;
    localparam int K_MISS = 3;
    localparam int K_HIT  = 4;

    typedef struct {
        bit         shot;
        logic [7:0] xy;
        int         kind;
        bit         wr;
        logic [1:0] wdata;
        int         ships;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_req;
    logic       place_req;
    logic [7:0] place_xy;
    logic       shot_req;
    logic [7:0] shot_xy;
    logic [7:0] mem_addr;
    logic [1:0] mem_wdata;
    logic       mem_w_nr;
    logic [1:0] mem_rdata;
    logic       busy;
    logic       clear_done;
    logic       place_ok;
    logic       place_err;
    logic       shot_done;
    logic       shot_hit;
    logic       shot_err;
    logic [4:0] ships_left;

    logic [1:0] mem [0:255] = '{default: 2'b11};
    int         wr_count = 0;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    board_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .place_req  (place_req),
        .place_xy   (place_xy),
        .shot_req   (shot_req),
        .shot_xy    (shot_xy),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_w_nr   (mem_w_nr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .clear_done (clear_done),
        .place_ok   (place_ok),
        .place_err  (place_err),
        .shot_done  (shot_done),
        .shot_hit   (shot_hit),
        .shot_err   (shot_err),
        .ships_left (ships_left)
    );

    // Board RAM: synchronous read (data one clk after address), write on mem_w_nr.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_w_nr) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input string what, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s %s: got %0d, expected %0d", tag, what, act, exp);
    endtask

    function automatic int any_pulse();
        return int'(place_ok | place_err | shot_done | shot_err | clear_done);
    endfunction

    task automatic do_req(input string tag, input bit shot, input logic [7:0] xy, input int kind,
                          input bit wr, input logic [1:0] wdata, input int ships);
        int wc0;
        @(negedge clk);
        if (shot) begin
            shot_req = 1'b1;
            shot_xy  = xy;
        end else begin
            place_req = 1'b1;
            place_xy  = xy;
        end
        wc0 = wr_count;
        @(negedge clk);
        shot_req  = 1'b0;
        place_req = 1'b0;
        if (kind == K_OOR) begin
            chk(tag, "err at N+1", int'(shot ? shot_err : place_err), 1);
            chk(tag, "busy at N+1", int'(busy), 0);
            chk(tag, "w_nr at N+1", int'(mem_w_nr), 0);
            @(negedge clk);
            chk(tag, "pulses at N+2", any_pulse(), 0);
            chk(tag, "writes", wr_count - wc0, 0);
            chk(tag, "ships_left", int'(ships_left), ships);
            return;
        end
        chk(tag, "busy at N+1", int'(busy), 1);
        chk(tag, "rd addr at N+1", int'(mem_addr), int'(xy));
        chk(tag, "w_nr/wdata at N+1", int'({mem_w_nr, mem_wdata}), 0);
        chk(tag, "pulses at N+1", any_pulse(), 0);
        @(negedge clk);
        chk(tag, "w_nr/wdata at N+2", int'({mem_w_nr, mem_wdata}), 0);
        chk(tag, "pulses at N+2", any_pulse(), 0);
        @(negedge clk);
        if (shot) begin
            chk(tag, "shot_done at N+3", int'(shot_done), 1);
            chk(tag, "shot_hit at N+3", int'(shot_hit), int'(kind == K_HIT));
            chk(tag, "place pulses at N+3", int'(place_ok | place_err), 0);
        end else begin
            chk(tag, "place_ok at N+3", int'(place_ok), int'(kind == K_POK));
            chk(tag, "place_err at N+3", int'(place_err), int'(kind == K_PERR));
            chk(tag, "shot_done at N+3", int'(shot_done), 0);
        end
        chk(tag, "w_nr at N+3", int'(mem_w_nr), int'(wr));
        if (wr) begin
            chk(tag, "wdata at N+3", int'(mem_wdata), int'(wdata));
            chk(tag, "wr addr at N+3", int'(mem_addr), int'(xy));
        end
        chk(tag, "ships_left at N+3", int'(ships_left), ships);
        @(negedge clk);
        chk(tag, "busy at N+4", int'(busy), 0);
        chk(tag, "pulses at N+4", any_pulse(), 0);
        chk(tag, "writes", wr_count - wc0, int'(wr));
        if (wr) chk(tag, "cell after write", int'(mem[xy]), int'(wdata));
    endtask

    // Waits for clear_done from cycle 1 of a clear; returns the cycle it arrived in and stray pulses.
    task automatic wait_clear(output int n, output int stray);
        n = 1;
        stray = 0;
        while (!clear_done && n < 400) begin
            @(negedge clk);
            n++;
            if (place_ok | place_err | shot_done | shot_err) stray++;
        end
    endtask

    initial begin
        vec_t vecs[16];
        int   wc0;
        int   bad;
        int   n;
        int   stray;

        vecs[0]  = '{0, 8'h35, K_POK,  1, 2'b01, 1};
        vecs[1]  = '{0, 8'h35, K_POK,  1, 2'b00, 0};
        vecs[2]  = '{0, 8'h35, K_POK,  1, 2'b01, 1};
        vecs[3]  = '{0, 8'h00, K_POK,  1, 2'b01, 2};
        vecs[4]  = '{0, 8'hBB, K_POK,  1, 2'b01, 3};
        vecs[5]  = '{1, 8'h35, K_HIT,  1, 2'b11, 2};
        vecs[6]  = '{1, 8'h35, K_HIT,  0, 2'b00, 2};
        vecs[7]  = '{1, 8'h44, K_MISS, 1, 2'b10, 2};
        vecs[8]  = '{1, 8'h44, K_MISS, 0, 2'b00, 2};
        vecs[9]  = '{0, 8'h35, K_PERR, 0, 2'b00, 2};
        vecs[10] = '{0, 8'h44, K_PERR, 0, 2'b00, 2};
        vecs[11] = '{1, 8'hC0, K_OOR,  0, 2'b00, 2};
        vecs[12] = '{0, 8'h0C, K_OOR,  0, 2'b00, 2};
        vecs[13] = '{1, 8'hBB, K_HIT,  1, 2'b11, 1};
        vecs[14] = '{0, 8'h00, K_POK,  1, 2'b00, 0};
        vecs[15] = '{1, 8'h00, K_MISS, 1, 2'b10, 0};

        rst       = 1'b0;
        clear_req = 1'b0;
        place_req = 1'b0;
        shot_req  = 1'b0;
        place_xy  = 8'h00;
        shot_xy   = 8'h00;

        // Reset values, then the automatic clear after release.
        repeat (2) @(negedge clk);
        chk("reset", "busy", int'(busy), 0);
        chk("reset", "mem outputs", int'({mem_addr, mem_wdata, mem_w_nr}), 0);
        chk("reset", "pulses+hit", any_pulse() | int'(shot_hit), 0);
        chk("reset", "ships_left", int'(ships_left), 0);
        rst = 1'b1;
        wc0 = wr_count;
        bad = 0;
        for (int x = 0; x < 12; x++) begin
            for (int y = 0; y < 12; y++) begin
                @(negedge clk);
                if (!busy || !mem_w_nr || mem_wdata != 2'b00 || mem_addr != {x[3:0], y[3:0]}) bad++;
            end
        end
        chk("init clear", "bad cycles", bad, 0);
        @(negedge clk);
        chk("init clear", "clear_done", int'(clear_done), 1);
        chk("init clear", "busy", int'(busy), 0);
        chk("init clear", "w_nr", int'(mem_w_nr), 0);
        chk("init clear", "ships_left", int'(ships_left), 0);
        chk("init clear", "writes", wr_count - wc0, 144);
        bad = 0;
        for (int x = 0; x < 12; x++) begin
            for (int y = 0; y < 12; y++) begin
                if (mem[x * 16 + y] != 2'b00) bad++;
            end
        end
        chk("init clear", "non-empty cells", bad, 0);
        @(negedge clk);
        chk("init clear", "clear_done width", int'(clear_done), 0);

        // Directed place/shot table.
        for (int i = 0; i < 16; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].shot, vecs[i].xy, vecs[i].kind,
                   vecs[i].wr, vecs[i].wdata, vecs[i].ships);
        end

        // Fill to the ship limit, then one more place must fail.
        for (int i = 0; i < 20; i++) begin
            do_req($sformatf("fill%0d", i), 1'b0, 8'(8'h60 + (i / 10) * 16 + (i % 10)),
                   K_POK, 1'b1, 2'b01, i + 1);
        end
        do_req("place21", 1'b0, 8'h80, K_PERR, 1'b0, 2'b00, 20);
        do_req("shot_at_max", 1'b1, 8'h60, K_HIT, 1'b1, 2'b11, 19);

        // Simultaneous clear/shot/place: only the clear runs; a place during clear is dropped.
        @(negedge clk);
        clear_req = 1'b1;
        shot_req  = 1'b1;
        shot_xy   = 8'h61;
        place_req = 1'b1;
        place_xy  = 8'h90;
        wc0 = wr_count;
        @(negedge clk);
        clear_req = 1'b0;
        shot_req  = 1'b0;
        place_req = 1'b0;
        chk("simul", "busy", int'(busy), 1);
        chk("simul", "first clear write", int'({mem_addr, mem_w_nr, mem_wdata}), 8'h00 * 8 + 4);
        chk("simul", "pulses", any_pulse(), 0);
        repeat (3) @(negedge clk);
        place_req = 1'b1;
        place_xy  = 8'h22;
        @(negedge clk);
        place_req = 1'b0;
        wait_clear(n, stray);
        n = n + 4;
        chk("simul", "clear_done cycle", n, 145);
        chk("simul", "stray pulses", stray, 0);
        chk("simul", "writes", wr_count - wc0, 144);
        chk("simul", "ships_left", int'(ships_left), 0);
        repeat (4) @(negedge clk);
        chk("simul", "idle after", int'(busy) | any_pulse(), 0);
        chk("simul", "shot cell 61", int'(mem[8'h61]), 0);
        chk("simul", "place cell 90", int'(mem[8'h90]), 0);
        chk("simul", "dropped place cell 22", int'(mem[8'h22]), 0);

        // Reset during CHK of a place: no write, state cleared, clear restarts.
        do_req("pre_abort", 1'b0, 8'h33, K_POK, 1'b1, 2'b01, 1);
        wc0 = wr_count;
        @(negedge clk);
        place_req = 1'b1;
        place_xy  = 8'h22;
        @(negedge clk);
        place_req = 1'b0;
        chk("abort", "busy in RD", int'(busy), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort", "mem outputs", int'({mem_addr, mem_wdata, mem_w_nr}), 0);
        chk("abort", "pulses+hit", any_pulse() | int'(shot_hit), 0);
        chk("abort", "ships_left", int'(ships_left), 0);
        repeat (2) @(negedge clk);
        chk("abort", "writes during reset", wr_count - wc0, 0);
        chk("abort", "cell 22", int'(mem[8'h22]), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort", "clear restarts", int'({busy, mem_w_nr, mem_addr}), 2 * 256 + 256);
        wait_clear(n, stray);
        chk("abort", "clear_done cycle", n, 145);
        chk("abort", "stray pulses", stray, 0);
        chk("abort", "cell 33 cleared", int'(mem[8'h33]), 0);
        chk("abort", "ships_left", int'(ships_left), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
